mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the pipelined RV32 core. It grants one requester at a time, holds the memory request until the memory acknowledges, returns read data and a one-cycle ready pulse to the winner, and flags accesses that exceed a cycle budget. The hazard logic uses the not-ready requests as its stall sources for fetch and memory stages.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 64, maximum cycles in a busy state before an access is aborted (≥2)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  fetch read request; held until `i_ready`
- `i_addr`  in  ADDR_W  fetch address; stable while `i_req`
- `i_rdata`  out  DATA_W  fetch read data; valid with `i_ready`
- `i_ready`  out  1  fetch access complete (1-cycle pulse)
- `d_req`  in  1  data request; held until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  store byte enables
- `d_rdata`  out  DATA_W  load data; valid with `d_ready`
- `d_ready`  out  1  data access complete (1-cycle pulse)
- `err`  out  1  1-cycle pulse, coincident with ready, when the access timed out
- `mem_req`  out  1  memory request; held until `mem_ack`
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  registered command
- `mem_ack`  in  1  memory completed current command
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_ack`

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE: if `d_req`, go to DBUSY and latch `d_we/d_addr/d_wdata/d_be` into the command registers. Otherwise, if `i_req`, go to IBUSY and latch `i_addr` with `we=0` and `be=0`. Data has fixed priority: the memory-stage instruction is older, and fetch is stalled behind it anyway.
- IBUSY/DBUSY: `mem_req=1`. The command registers are frozen; requester input changes are ignored.
- When `mem_ack`=1 in a busy state:
  - The owner's ready is asserted combinationally in that cycle.
  - The owner's rdata equals `mem_rdata`.
  - The next state is IDLE.
- Stores also complete via `d_ready`; `d_rdata` is don't-care for a store.
- A wait counter clears on entry to a busy state and increments each busy cycle without `mem_ack`.
- If the counter reaches TIMEOUT-1 without an ack:
  - Owner's ready=1 and `err`=1 in that cycle.
  - rdata is forced to 0.
  - `mem_req` drops next cycle, and the next state is IDLE.
- `mem_ack` in IDLE is ignored.
- Ready is never asserted to a non-owner. `i_ready` and `d_ready` are never high together.
- Requesters must drop or renew their request in the cycle after ready. A request still high in IDLE is treated as a new access.
- Reset (any state, including mid-access):
  - Next state is IDLE.
  - `mem_req`, `i_ready`, `d_ready`, `err` are 0.
  - Command registers and counter are 0.
  - Any later `mem_ack` for the abandoned access is ignored.

## Timing
- Request seen in IDLE at cycle N → `mem_req` high from N+1.
- With `mem_ack` at cycle N+1+k (k ≥ 0 wait cycles), ready is at N+1+k.
- Minimum request-to-ready latency is 1 cycle (k=0). Minimum back-to-back spacing between the same requester's accesses is 2 cycles, because of the IDLE cycle between accesses.
- Both requests arriving together in IDLE: data is served first, fetch next. Fetch completes no earlier than 2 cycles after `d_ready`.
- All outputs except the ready, `err` and rdata paths are registered.

## Test plan
- Reset then `i_req=1`, `i_addr=0x100`, memory acks 1 cycle after `mem_req` rises:
  - `mem_addr=0x100`, `mem_we=0`.
  - `i_ready` pulses once with `i_rdata=mem_rdata`.
  - `d_ready=0` throughout.
- `i_req` and `d_req` (store, addr 0x2000, wdata 0xDEADBEEF, be 0xF) rise in the same cycle:
  - The data command is issued first with `mem_we=1`.
  - `d_ready` pulses, then the IDLE cycle, then the fetch is issued.
  - `i_ready` pulses exactly once.
- Load to 0x44, memory inserts 5 wait cycles: `mem_req` is held for 6 cycles with stable `mem_addr`, and `d_ready` coincides with `mem_ack`.
- `TIMEOUT=8`, memory never acks:
  - `d_ready=1`, `err=1`, `d_rdata=0` on the 8th busy cycle.
  - `mem_req=0` the next cycle.
- `reset` asserted during DBUSY, and memory acks on the following cycle:
  - No ready or `err` pulse.
  - State is IDLE.
  - `mem_req=0` from the cycle after reset.
- `mem_ack` pulsed while in IDLE with no requests: no ready, no state change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory bus bundle for mem_port_arbiter
// Purpose: groups the fetch port (i_*), the data port (d_*), the timeout flag
//          and the single memory command port (mem_*) into one bundle.
// Modports:
//   master - arbiter view: takes requests and memory responses, drives
//            ready/rdata/err and the memory command.
//   slave  - environment view: drives requests and memory responses.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_ready;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;

    logic                  err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port unified memory
// Purpose: grants the memory to one requester at a time (data before fetch),
//          holds a registered command until mem_ack, returns rdata with a
//          one-cycle ready pulse, and aborts accesses that exceed TIMEOUT
//          busy cycles (ready + err, rdata forced to 0).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - mem_port_arbiter_if.master (fetch port, data port, err, memory port)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IBUSY = 2'd1,
        S_DBUSY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                mem_req_q, mem_req_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [BE_W-1:0]     cmd_be_q, cmd_be_d;

    logic busy;
    logic timeout_hit;
    logic done;

    // An ack on the last budgeted cycle still counts as a normal completion.
    assign busy        = (state_q != S_IDLE);
    assign timeout_hit = busy && !bus.mem_ack && (wait_q == WAIT_LAST);
    assign done        = busy && (bus.mem_ack || timeout_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.d_req) begin
                    state_d = S_DBUSY;
                end else if (bus.i_req) begin
                    state_d = S_IBUSY;
                end
            end
            S_IBUSY, S_DBUSY: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command registers load only on the IDLE->busy transition and stay frozen
    // while busy, so requester input changes mid-access have no effect.
    always_comb begin
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_be_d    = cmd_be_q;
        wait_d      = '0;
        mem_req_d   = (state_d != S_IDLE);
        if (state_q == S_IDLE) begin
            if (bus.d_req) begin
                cmd_we_d    = bus.d_we;
                cmd_addr_d  = bus.d_addr;
                cmd_wdata_d = bus.d_wdata;
                cmd_be_d    = bus.d_be;
            end else if (bus.i_req) begin
                cmd_we_d    = 1'b0;
                cmd_addr_d  = bus.i_addr;
                cmd_wdata_d = '0;
                cmd_be_d    = '0;
            end
        end else if (!bus.mem_ack) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_be_q    <= '0;
        end else begin
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_be_q    <= cmd_be_d;
        end
    end

    // Reset also masks the completion path so an access abandoned by reset
    // never reports ready or err, even if mem_ack lands in the reset cycle.
    always_comb begin
        bus.i_ready = 1'b0;
        bus.d_ready = 1'b0;
        bus.err     = 1'b0;
        bus.i_rdata = '0;
        bus.d_rdata = '0;
        if (!reset && done) begin
            bus.err = timeout_hit;
            if (state_q == S_IBUSY) begin
                bus.i_ready = 1'b1;
                bus.i_rdata = timeout_hit ? '0 : bus.mem_rdata;
            end else begin
                bus.d_ready = 1'b1;
                bus.d_rdata = timeout_hit ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_we_q;
    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_wdata = cmd_wdata_q;
    assign bus.mem_be    = cmd_be_q;
endmodule
